// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave with RX/TX FIFOs, all logic in the clk domain.
//   clk, rst        system clock, async active-high reset
//   sclk, cs, mosi  SPI inputs from the master (asynchronous, synchronised here)
//   miso, miso_oe   SPI output and its enable (enable = selected)
//   tx_data/tx_wr_en/tx_full            TX FIFO write side
//   rx_data/rx_rd_en/rx_empty           RX FIFO read side (show-ahead head)
//   rx_overflow, tx_underrun            one-cycle event pulses
//   busy            synchronised chip select is active

module spi_slave_gen_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FULL_CNT = AW1'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr != do_rd) cnt_q <= do_wr ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

module spi_slave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr_en,
  output logic                  tx_full,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rd_en,
  output logic                  rx_empty,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic IDLE = (CPOL != 0);

  logic [2:0] sclk_q;   // [1:0] synchroniser, [2] previous for edge detect
  logic [1:0] cs_q, mosi_q, init_q;
  logic       arm_q, sel_q, sel;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic done_q, done_d, ovf_q, ovf_d, unr_q, unr_d;
  logic rise, fall, lead, trail, sample, shift_e, start_e, load, shift;
  logic tx_empty, rx_full;
  logic [DATA_WIDTH-1:0] tx_head;

  // arm_q only sets once cs has been seen inactive after reset, so a master
  // still holding cs low across a reset cannot resume a stale transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= {3{IDLE}};
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
      init_q <= 2'b00;
      arm_q  <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[0], cs};
      mosi_q <= {mosi_q[0], mosi};
      init_q <= {init_q[0], 1'b1};
      arm_q  <= arm_q | (init_q[1] & cs_q[1]);
      sel_q  <= sel;
    end
  end

  assign sel     = arm_q & ~cs_q[1];
  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign lead    = IDLE ? fall : rise;
  assign trail   = IDLE ? rise : fall;
  assign sample  = sel & ((CPHA != 0) ? trail : lead);
  assign shift_e = sel & ((CPHA != 0) ? lead : trail);
  assign start_e = sel & ~sel_q;

  always_comb begin
    cnt_d   = cnt_q;
    rx_sh_d = rx_sh_q;
    tx_sh_d = tx_sh_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    if (!sel) begin
      cnt_d   = '0;
      rx_sh_d = '0;
      tx_sh_d = '0;
    end else begin
      if (sample) begin
        if (LSB_FIRST != 0) rx_sh_d = {mosi_q[1], rx_sh_q[DATA_WIDTH-1:1]};
        else                rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_q[1]};
        done_d = (cnt_q == LAST);
        cnt_d  = done_d ? '0 : cnt_q + 1'b1;
      end
      // A shift edge with the counter at 0 is a word boundary: with CPHA=0
      // the new word is already loaded (hold it), with CPHA=1 it loads here.
      shift = shift_e & (cnt_q != '0);
      if (CPHA != 0) load = shift_e & (cnt_q == '0);
      else           load = start_e | done_q;
      if (load)       tx_sh_d = tx_empty ? '0 : tx_head;
      else if (shift) tx_sh_d = (LSB_FIRST != 0) ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end
  end

  assign ovf_d = done_q & rx_full;
  assign unr_d = load & tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unr_q   <= unr_d;
    end
  end

  spi_slave_gen_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr_en_i(tx_wr_en), .wr_data_i(tx_data),
    .rd_en_i(load), .rd_data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  // Word completes the cycle after its last sample; that is when it is pushed.
  spi_slave_gen_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr_en_i(done_q), .wr_data_i(rx_sh_q),
    .rd_en_i(rx_rd_en), .rd_data_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign miso        = sel & ((LSB_FIRST != 0) ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]);
  assign miso_oe     = sel;
  assign busy        = sel;
  assign rx_overflow = ovf_q;
  assign tx_underrun = unr_q;
endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: one default instance (index 0) and four
// 16-bit LSB-first instances covering SPI modes 0..3 (indices 1..4).
module tb_spi_slave_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sclk_a [5], cs_a [5], mosi_a [5], miso_a [5], oe_a [5], wr_a [5];
  logic full_a [5], rd_a [5], empty_a [5], ovf_a [5], unr_a [5], busy_a [5];
  logic [7:0]  txd0, rxd0;
  logic [15:0] txd16 [1:4], rxd16 [1:4];

  spi_slave_gen u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk_a[0]), .cs(cs_a[0]), .mosi(mosi_a[0]),
    .miso(miso_a[0]), .miso_oe(oe_a[0]), .tx_data(txd0), .tx_wr_en(wr_a[0]),
    .tx_full(full_a[0]), .rx_data(rxd0), .rx_rd_en(rd_a[0]), .rx_empty(empty_a[0]),
    .rx_overflow(ovf_a[0]), .tx_underrun(unr_a[0]), .busy(busy_a[0])
  );

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_slave_gen #(.DATA_WIDTH(16), .CPOL(m / 2), .CPHA(m % 2), .LSB_FIRST(1)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_a[m+1]), .cs(cs_a[m+1]), .mosi(mosi_a[m+1]),
      .miso(miso_a[m+1]), .miso_oe(oe_a[m+1]), .tx_data(txd16[m+1]), .tx_wr_en(wr_a[m+1]),
      .tx_full(full_a[m+1]), .rx_data(rxd16[m+1]), .rx_rd_en(rd_a[m+1]),
      .rx_empty(empty_a[m+1]), .rx_overflow(ovf_a[m+1]), .tx_underrun(unr_a[m+1]),
      .busy(busy_a[m+1])
    );
  end

  function automatic int dw(int k);         return (k == 0) ? 8 : 16;               endfunction
  function automatic bit lsbf(int k);       return (k != 0);                        endfunction
  function automatic bit pol(int k);        return (k == 0) ? 1'b0 : bit'((k - 1) / 2); endfunction
  function automatic bit pha(int k);        return (k == 0) ? 1'b0 : bit'((k - 1) % 2); endfunction
  function automatic logic [15:0] mask(int k); return (k == 0) ? 16'h00FF : 16'hFFFF; endfunction
  function automatic logic [15:0] rxdat(int k);
    if (k == 0) return {8'h00, rxd0};
    return rxd16[k];
  endfunction

  int checks = 0, errors = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters for the event flags.
  int ovf_cnt [5], unr_cnt [5];
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (ovf_a[k] === 1'b1) ovf_cnt[k]++;
      if (unr_a[k] === 1'b1) unr_cnt[k]++;
    end
  end

  // Reference model: word-level FIFOs and the word-start rule.
  logic [15:0] txq [$], rxq [$], exp_miso [$];
  int exp_unr, exp_ovf, ub, ob;
  logic [15:0] mw [20], mr [20];

  task automatic clk_wait(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    if (txq.size() > 0) exp_miso.push_back(txq.pop_front());
    else begin
      exp_miso.push_back(16'h0000);
      exp_unr++;
    end
  endtask

  task automatic start_test(int k);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sclk_a[i] = pol(i); cs_a[i] = 1'b1; mosi_a[i] = 1'b0; wr_a[i] = 1'b0; rd_a[i] = 1'b0;
    end
    clk_wait(3);
    rst = 1'b0;
    clk_wait(8);
    txq.delete(); rxq.delete(); exp_miso.delete();
    exp_unr = 0; exp_ovf = 0;
    ub = unr_cnt[k]; ob = ovf_cnt[k];
  endtask

  task automatic tx_wr(int k, logic [15:0] v);
    if (k == 0) txd0 = v[7:0]; else txd16[k] = v;
    wr_a[k] = 1'b1;
    clk_wait(1);
    wr_a[k] = 1'b0;
    if (txq.size() < 16) txq.push_back(v);
  endtask

  task automatic rx_drain(int k, string tag);
    while (rxq.size() > 0) begin
      chk({tag, "_rx"}, 32'(rxdat(k)), 32'(rxq.pop_front()));
      rd_a[k] = 1'b1;
      clk_wait(1);
      rd_a[k] = 1'b0;
    end
    chk({tag, "_rxempty"}, 32'(empty_a[k]), 32'd1);
  endtask

  task automatic flag_chk(int k, string tag);
    chk({tag, "_unr"}, 32'(unr_cnt[k] - ub), 32'(exp_unr));
    chk({tag, "_ovf"}, 32'(ovf_cnt[k] - ob), 32'(exp_ovf));
  endtask

  // Bit-level SPI master: sends mw[0..n-1]; the last word stops after 'cut' bits.
  task automatic xfer(int k, int n, int cut);
    int d, idx;
    d = dw(k);
    cs_a[k] = 1'b0;
    clk_wait(10);
    for (int j = 0; j < n; j++) begin
      mr[j] = 16'h0000;
      for (int i = 0; i < d; i++) begin
        if (j == n - 1 && i >= cut) break;
        idx = lsbf(k) ? i : d - 1 - i;
        if (!pha(k)) begin
          mosi_a[k] = mw[j][idx];
          clk_wait(8);
          mr[j][idx] = miso_a[k];
          sclk_a[k] = ~pol(k);
          clk_wait(8);
          sclk_a[k] = pol(k);
        end else begin
          sclk_a[k] = ~pol(k);
          mosi_a[k] = mw[j][idx];
          clk_wait(8);
          mr[j][idx] = miso_a[k];
          sclk_a[k] = pol(k);
          clk_wait(8);
        end
      end
    end
    clk_wait(10);
    cs_a[k] = 1'b1;
    mosi_a[k] = 1'b0;
    clk_wait(10);
  endtask

  // Predict from the model, run the master, compare the words read on miso.
  task automatic run(int k, int n, int cut, string tag);
    int nfull;
    bit part;
    nfull = (cut >= dw(k)) ? n : n - 1;
    part  = (cut > 0) && (cut < dw(k));
    exp_miso.delete();
    if (!pha(k)) repeat (1 + nfull) m_start();
    else         repeat (nfull + (part ? 1 : 0)) m_start();
    for (int j = 0; j < nfull; j++) begin
      if (rxq.size() < 16) rxq.push_back(mw[j]);
      else exp_ovf++;
    end
    xfer(k, n, cut);
    for (int j = 0; j < nfull; j++) chk({tag, "_miso"}, 32'(mr[j]), 32'(exp_miso[j]));
  endtask

  initial begin
    txd0 = '0;
    for (int i = 1; i < 5; i++) txd16[i] = '0;
    for (int i = 0; i < 5; i++) begin
      sclk_a[i] = pol(i); cs_a[i] = 1'b1; mosi_a[i] = 1'b0; wr_a[i] = 1'b0; rd_a[i] = 1'b0;
    end
    #22;
    for (int k = 0; k < 5; k++) begin
      chk("reset_rxempty", 32'(empty_a[k]), 32'd1);
      chk("reset_txfull",  32'(full_a[k]),  32'd0);
      chk("reset_miso",    32'(miso_a[k]),  32'd0);
      chk("reset_oe",      32'(oe_a[k]),    32'd0);
      chk("reset_busy",    32'(busy_a[k]),  32'd0);
      chk("reset_ovf",     32'(ovf_a[k]),   32'd0);
      chk("reset_unr",     32'(unr_a[k]),   32'd0);
    end

    // Basic mode-0 byte exchange.
    start_test(0);
    tx_wr(0, 16'h00A5);
    mw[0] = 16'h003C;
    run(0, 1, 8, "basic");
    chk("basic_rxne", 32'(empty_a[0]), 32'd0);
    rx_drain(0, "basic");
    flag_chk(0, "basic");

    // Two back-to-back 16-bit words in every SPI mode.
    for (int k = 1; k < 5; k++) begin
      start_test(k);
      tx_wr(k, 16'($urandom));
      tx_wr(k, 16'($urandom));
      mw[0] = 16'h1234;
      mw[1] = 16'hBEEF;
      run(k, 2, 16, $sformatf("mode%0d", k - 1));
      rx_drain(k, $sformatf("mode%0d", k - 1));
      flag_chk(k, $sformatf("mode%0d", k - 1));
    end

    // RX overflow: one more word than the FIFO holds, no reads.
    start_test(0);
    for (int i = 0; i < 16; i++) tx_wr(0, 16'($urandom) & mask(0));
    for (int j = 0; j < 17; j++) mw[j] = 16'($urandom) & mask(0);
    run(0, 17, 8, "ovf");
    chk("ovf_full_pulse", 32'(ovf_cnt[0] - ob), 32'd1);
    rx_drain(0, "ovf");
    flag_chk(0, "ovf");

    // TX underrun on a CPHA=1 instance: exactly one word start, empty FIFO.
    start_test(2);
    mw[0] = 16'($urandom);
    run(2, 1, 16, "unr");
    chk("unr_miso_zero", 32'(mr[0]), 32'd0);
    rx_drain(2, "unr");
    flag_chk(2, "unr");

    // cs dropped after 3 bits, then a clean 0x81.
    start_test(0);
    tx_wr(0, 16'h0011);
    mw[0] = 16'($urandom) & mask(0);
    run(0, 1, 3, "abort");
    mw[0] = 16'h0081;
    run(0, 1, 8, "abort2");
    rx_drain(0, "abort");
    flag_chk(0, "abort");

    // Reset mid-word, then no resume until cs is released and re-asserted.
    start_test(0);
    tx_wr(0, 16'h00C3);
    mw[0] = 16'h005A;
    run(0, 1, 8, "pre");
    for (int i = 0; i < 16; i++) tx_wr(0, 16'h00FF);
    chk("rst_txfull_pre", 32'(full_a[0]), 32'd1);
    cs_a[0] = 1'b0;
    clk_wait(10);
    mosi_a[0] = 1'b1;
    clk_wait(8);
    chk("rst_miso_pre", 32'(miso_a[0]), 32'd1);
    sclk_a[0] = 1'b1; clk_wait(8);
    sclk_a[0] = 1'b0; clk_wait(8);
    tx_wr(0, 16'h00FF);
    chk("rst_txfull_mid", 32'(full_a[0]),  32'd1);
    chk("rst_busy_mid",   32'(busy_a[0]),  32'd1);
    chk("rst_rxne_mid",   32'(empty_a[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_now_miso",    32'(miso_a[0]),  32'd0);
    chk("rst_now_oe",      32'(oe_a[0]),    32'd0);
    chk("rst_now_busy",    32'(busy_a[0]),  32'd0);
    chk("rst_now_rxempty", 32'(empty_a[0]), 32'd1);
    chk("rst_now_txfull",  32'(full_a[0]),  32'd0);
    chk("rst_now_ovf",     32'(ovf_a[0]),   32'd0);
    chk("rst_now_unr",     32'(unr_a[0]),   32'd0);
    clk_wait(3);
    rst = 1'b0;
    clk_wait(12);
    chk("rst_hold_busy", 32'(busy_a[0]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      mosi_a[0] = 1'($urandom);
      clk_wait(8); sclk_a[0] = 1'b1;
      clk_wait(8); sclk_a[0] = 1'b0;
    end
    clk_wait(6);
    chk("rst_hold_busy2", 32'(busy_a[0]),  32'd0);
    chk("rst_hold_rx",    32'(empty_a[0]), 32'd1);
    chk("rst_hold_miso",  32'(miso_a[0]),  32'd0);
    cs_a[0] = 1'b1;
    clk_wait(10);
    txq.delete(); rxq.delete(); exp_unr = 0; exp_ovf = 0;
    ub = unr_cnt[0]; ob = ovf_cnt[0];
    tx_wr(0, 16'h0066);
    mw[0] = 16'h0099;
    run(0, 1, 8, "resume");
    rx_drain(0, "resume");
    flag_chk(0, "resume");

    // Randomized traffic on every instance.
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 2; r++) begin
        int n, ntx;
        start_test(k);
        n   = $urandom_range(1, 4);
        ntx = $urandom_range(0, n);
        for (int i = 0; i < ntx; i++) tx_wr(k, 16'($urandom) & mask(k));
        for (int j = 0; j < n; j++) mw[j] = 16'($urandom) & mask(k);
        run(k, n, dw(k), $sformatf("rnd%0d", k));
        rx_drain(k, $sformatf("rnd%0d", k));
        flag_chk(k, $sformatf("rnd%0d", k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
